// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OpMultu = 2'b00,
        OpMult  = 2'b01,
        OpDivu  = 2'b10,
        OpDiv   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam int unsigned ITER_N  = 32;
    localparam int unsigned EARLY_N = 16;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of a signed operand; unsigned ops pass through untouched.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-facing signal bundle of the mul/div unit; master is the EX stage, slave the unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        flush;
    logic        mf_req;
    logic        mf_sel;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    modport master (
        output start, op, opA, opB, flush, mf_req, mf_sel,
        input  stall, busy, done, hi, lo, mf_data
    );

    modport slave (
        input  start, op, opA, opB, flush, mf_req, mf_sel,
        output stall, busy, done, hi, lo, mf_data
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration: shift-add multiply or restoring divide on {hi, lo}.
module muldiv_step (
    input  logic        i_is_div,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_opnd,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : 33'd0);
        w_shift = {i_hi, i_lo[31]};
        w_diff  = w_shift - {1'b0, i_opnd};
        o_hi    = w_sum[32:1];
        o_lo    = {w_sum[0], i_lo[31:1]};
        if (i_is_div) begin
            // Borrow out of bit 32 means the partial remainder is smaller than the divisor.
            if (!w_diff[32]) begin
                o_hi = w_diff[31:0];
                o_lo = {i_lo[30:0], 1'b1};
            end else begin
                o_hi = w_shift[31:0];
                o_lo = {i_lo[30:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MIPS HI/LO multiply/divide controller with pipeline stall and flush.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies with |opB| < 2^16 finish after 16 steps.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    state_e      r_state;
    state_e      w_state_nxt;
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_main;
    logic        r_neg_rem;
    logic        r_div0;
    logic [31:0] r_opnd;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
`ifdef MULDIV_EARLY_OUT_EN
    logic        r_early;
`endif

    op_e         w_op;
    logic        w_signed;
    logic        w_is_div;
    logic        w_accept;
    logic        w_last;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_step_hi;
    logic [31:0] w_step_lo;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_op     = op_e'(bus.op);
    assign w_signed = (w_op == OpMult) || (w_op == OpDiv);
    assign w_is_div = (w_op == OpDivu) || (w_op == OpDiv);
    assign w_mag_a  = abs32(bus.opA, w_signed);
    assign w_mag_b  = abs32(bus.opB, w_signed);
    assign w_accept = (r_state == StIdle) && bus.start && !bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_last = (r_cnt == 6'(ITER_N - 1)) || (r_early && (r_cnt == 6'(EARLY_N - 1)));
`else
    assign w_last = (r_cnt == 6'(ITER_N - 1));
`endif

    muldiv_step u_step (
        .i_is_div (r_is_div),
        .i_hi     (r_acc_hi),
        .i_lo     (r_acc_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bus.busy    = (r_state != StIdle);
        bus.stall   = (r_state != StIdle) && (bus.start || bus.mf_req) && !bus.flush;
        bus.done    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (bus.flush) begin
                    w_state_nxt = StIdle;
                end else if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                bus.done    = !bus.flush;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Sign correction applied to the unsigned iteration result in the DONE cycle.
    always_comb begin
        w_prod = {r_acc_hi, r_acc_lo};
`ifdef MULDIV_EARLY_OUT_EN
        if (r_early) begin
            w_prod = {16'h0000, r_acc_hi, r_acc_lo[31:16]};
        end
`endif
        if (r_neg_main) begin
            w_prod = ~w_prod + 64'd1;
        end
        w_quo = r_neg_main ? (~r_acc_lo + 32'd1) : r_acc_lo;
        w_rem = r_neg_rem ? (~r_acc_hi + 32'd1) : r_acc_hi;
        if (r_div0) begin
            w_quo = DIV0_LO;
        end
        if (r_is_div) begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end else begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div0     <= 1'b0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            r_early    <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_cnt      <= '0;
                r_is_div   <= w_is_div;
                r_neg_main <= w_signed && (bus.opA[31] ^ bus.opB[31]);
                r_neg_rem  <= w_signed && bus.opA[31];
                r_div0     <= w_is_div && (bus.opB == 32'd0);
                r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
                r_acc_hi   <= '0;
                r_acc_lo   <= w_is_div ? w_mag_a : w_mag_b;
`ifdef MULDIV_EARLY_OUT_EN
                r_early    <= !w_is_div && (w_mag_b[31:16] == 16'h0000);
`endif
            end
            if ((r_state == StRun) && !bus.flush) begin
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
                r_cnt    <= r_cnt + 6'd1;
            end
            if ((r_state == StDone) && !bus.flush) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.mf_data = bus.mf_sel ? r_lo : r_hi;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl: results, latency, stall, flush and reset.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SMALL_EDGES = 18;
`else
    localparam int SMALL_EDGES = 34;
`endif
    localparam int FULL_EDGES = 34;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_fail = 0;

    muldiv_if bus ();

    muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op and counts edges (accept included) until busy drops; observes done/stall.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int dones, output bit stall_seen);
        tick();
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        edges      = 0;
        dones      = 0;
        stall_seen = 1'b0;
        @(negedge clk);
        if (bus.stall) stall_seen = 1'b1;
        if (bus.done) dones++;
        tick();
        edges     = 1;
        bus.start = 1'b0;
        bus.opA   = 32'hDEAD_BEEF;
        bus.opB   = 32'h0000_0000;
        while (bus.busy && edges < 60) begin
            @(negedge clk);
            if (bus.stall) stall_seen = 1'b1;
            if (bus.done) dones++;
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1; bus.op = OpMultu; bus.opA = 32'd3; bus.opB = 32'd4;
        bus.mf_req = 1'b1; bus.mf_sel = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        n_cmp++; if (bus.mf_data !== 32'd0) begin n_fail++; $display("FAIL reset_mf got %h want 0", bus.mf_data); end
        rst = 1'b0;
        bus.start = 1'b0;
        bus.mf_req = 1'b0;
        bus.mf_sel = 1'b0;
    endtask

    task automatic test_multiply();
        int e;
        int d;
        bit s;
        run_op(OpMultu, 32'hFFFF_FFFF, 32'd2, e, d, s);
        n_cmp++; if (e !== SMALL_EDGES) begin n_fail++; $display("FAIL multu_latency got %0d want %0d", e, SMALL_EDGES); end
        n_cmp++; if (d !== 1) begin n_fail++; $display("FAIL multu_done_pulses got %0d want 1", d); end
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL multu_stall got %b want 0", s); end
        n_cmp++; if (bus.hi !== 32'h1) begin n_fail++; $display("FAIL multu_hi got %h want 1", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo got %h want fffffffe", bus.lo); end
        bus.mf_sel = 1'b0;
        #1;
        n_cmp++; if (bus.mf_data !== 32'h1) begin n_fail++; $display("FAIL mf_hi got %h want 1", bus.mf_data); end

        run_op(OpMult, 32'hFFFF_FFFD, 32'd5, e, d, s);
        n_cmp++; if (e !== SMALL_EDGES) begin n_fail++; $display("FAIL mult_latency got %0d want %0d", e, SMALL_EDGES); end
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got %h want fffffff1", bus.lo); end

        run_op(OpMult, 32'h8000_0000, 32'h0002_0000, e, d, s);
        n_cmp++; if (e !== FULL_EDGES) begin n_fail++; $display("FAIL mult_big_latency got %0d want %0d", e, FULL_EDGES); end
        n_cmp++; if (bus.hi !== 32'hFFFF_0000) begin n_fail++; $display("FAIL mult_min_hi got %h want ffff0000", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL mult_min_lo got %h want 0", bus.lo); end

        run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, d, s);
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi got %h want fffffffe", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h1) begin n_fail++; $display("FAIL multu_max_lo got %h want 1", bus.lo); end

        run_op(OpMultu, 32'd7, 32'd9, e, d, s);
        n_cmp++; if (e !== SMALL_EDGES) begin n_fail++; $display("FAIL multu_7x9_latency got %0d want %0d", e, SMALL_EDGES); end
        n_cmp++; if (bus.lo !== 32'd63) begin n_fail++; $display("FAIL multu_7x9_lo got %h want 3f", bus.lo); end
        n_cmp++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL multu_7x9_hi got %h want 0", bus.hi); end
    endtask

    task automatic test_divide();
        int e;
        int d;
        bit s;
        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, e, d, s);
        n_cmp++; if (e !== FULL_EDGES) begin n_fail++; $display("FAIL div_latency got %0d want %0d", e, FULL_EDGES); end
        n_cmp++; if (d !== 1) begin n_fail++; $display("FAIL div_done_pulses got %0d want 1", d); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo got %h want fffffffd", bus.lo); end
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi got %h want ffffffff", bus.hi); end

        run_op(OpDiv, 32'd7, 32'hFFFF_FFFE, e, d, s);
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_lo got %h want fffffffd", bus.lo); end
        n_cmp++; if (bus.hi !== 32'd1) begin n_fail++; $display("FAIL div_negb_hi got %h want 1", bus.hi); end

        run_op(OpDivu, 32'hFFFF_FFFF, 32'h10, e, d, s);
        n_cmp++; if (bus.lo !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL divu_big_lo got %h want 0fffffff", bus.lo); end
        n_cmp++; if (bus.hi !== 32'hF) begin n_fail++; $display("FAIL divu_big_hi got %h want f", bus.hi); end
    endtask

    task automatic test_div_by_zero();
        int e;
        int d;
        bit s;
        run_op(OpDivu, 32'd9, 32'd0, e, d, s);
        n_cmp++; if (e !== FULL_EDGES) begin n_fail++; $display("FAIL div0_latency got %0d want %0d", e, FULL_EDGES); end
        n_cmp++; if (bus.hi !== 32'd9) begin n_fail++; $display("FAIL divu0_hi got %h want 9", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo got %h want ffffffff", bus.lo); end

        run_op(OpDiv, 32'hFFFF_FFFB, 32'd0, e, d, s);
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL div0_hi got %h want fffffffb", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo got %h want ffffffff", bus.lo); end
    endtask

    task automatic test_mf_stall();
        int gaps;
        int cyc;
        tick();
        bus.start = 1'b1; bus.op = OpMultu; bus.opA = 32'd7; bus.opB = 32'd9;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.mf_req = 1'b1;
        bus.mf_sel = 1'b1;
        gaps = 0;
        cyc  = 0;
        while (bus.busy && cyc < 60) begin
            @(negedge clk);
            if (!bus.stall) gaps++;
            tick();
            cyc++;
        end
        n_cmp++; if (gaps !== 0) begin n_fail++; $display("FAIL mf_stall_gaps got %0d want 0", gaps); end
        @(negedge clk);
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mf_idle_stall got %b want 0", bus.stall); end
        n_cmp++; if (bus.mf_data !== 32'd63) begin n_fail++; $display("FAIL mf_lo_data got %h want 3f", bus.mf_data); end
        bus.mf_req = 1'b0;
        bus.mf_sel = 1'b0;
    endtask

    task automatic test_flush();
        int e;
        int d;
        bit s;
        run_op(OpDivu, 32'd100, 32'd7, e, d, s);
        n_cmp++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %h want e", bus.lo); end
        n_cmp++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %h want 2", bus.hi); end

        bus.start = 1'b1; bus.op = OpMultu; bus.opA = 32'hFFFF_FFFF; bus.opB = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_run_busy got %b want 0", bus.busy); end
        d = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) d++;
        end
        n_cmp++; if (d !== 0) begin n_fail++; $display("FAIL flush_run_done got %0d want 0", d); end
        n_cmp++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL flush_run_hi got %h want 2", bus.hi); end
        n_cmp++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL flush_run_lo got %h want e", bus.lo); end

        tick();
        bus.start = 1'b1; bus.op = OpMultu; bus.opA = 32'hFFFF_FFFF; bus.opB = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (32) tick();
        bus.flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_done_pulse got %b want 0", bus.done); end
        tick();
        bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_done_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL flush_done_lo got %h want e", bus.lo); end

        bus.start = 1'b1; bus.flush = 1'b1; bus.op = OpDivu; bus.opA = 32'd9; bus.opB = 32'd0;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.start = 1'b1; bus.op = OpDivu; bus.opA = 32'd100; bus.opB = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %b want 0", bus.stall); end
        n_cmp++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_lo got %h want 0", bus.lo); end
        rst = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        int gaps;
        int cyc;
        tick();
        bus.start = 1'b1; bus.op = OpMultu; bus.opA = 32'hFFFF_FFFF; bus.opB = 32'd2;
        tick();
        // The next instruction presents a divide while the multiply is still running.
        bus.op = OpDivu; bus.opA = 32'd9; bus.opB = 32'd0;
        gaps = 0;
        cyc  = 0;
        while (bus.busy && cyc < 60) begin
            @(negedge clk);
            if (!bus.stall) gaps++;
            tick();
            cyc++;
        end
        n_cmp++; if (cyc !== SMALL_EDGES - 1) begin n_fail++; $display("FAIL b2b_first_len got %0d want %0d", cyc, SMALL_EDGES - 1); end
        n_cmp++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_stall_gaps got %0d want 0", gaps); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_first_lo got %h want fffffffe", bus.lo); end
        @(negedge clk);
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_stall got %b want 0", bus.stall); end
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got %b want 1", bus.busy); end
        cyc = 0;
        while (bus.busy && cyc < 60) begin
            tick();
            cyc++;
        end
        n_cmp++; if (bus.hi !== 32'd9) begin n_fail++; $display("FAIL b2b_second_hi got %h want 9", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_second_lo got %h want ffffffff", bus.lo); end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.opA    = 32'd0;
        bus.opB    = 32'd0;
        bus.flush  = 1'b0;
        bus.mf_req = 1'b0;
        bus.mf_sel = 1'b0;
        test_reset();
        test_multiply();
        test_divide();
        test_div_by_zero();
        test_mf_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
